// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM state encoding and
// requester identifiers.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ZERO = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Command and response channels of requesters A and B toward the shared ALU.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender keeps valid and its payload stable until that edge.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic       a_req_valid;
  logic       a_req_ready;
  logic [2:0] a_op;
  logic [3:0] a_x;
  logic [3:0] a_y;
  logic       a_rsp_valid;
  logic       a_rsp_ready;
  logic [3:0] a_rsp_data;

  logic       b_req_valid;
  logic       b_req_ready;
  logic [2:0] b_op;
  logic [3:0] b_x;
  logic [3:0] b_y;
  logic       b_rsp_valid;
  logic       b_rsp_ready;
  logic [3:0] b_rsp_data;

  logic       busy;

  modport master (
    output a_req_valid, a_op, a_x, a_y, a_rsp_ready,
    output b_req_valid, b_op, b_x, b_y, b_rsp_ready,
    input  a_req_ready, a_rsp_valid, a_rsp_data,
    input  b_req_ready, b_rsp_valid, b_rsp_data,
    input  busy
  );

  modport slave (
    input  a_req_valid, a_op, a_x, a_y, a_rsp_ready,
    input  b_req_valid, b_op, b_x, b_y, b_rsp_ready,
    output a_req_ready, a_rsp_valid, a_rsp_data,
    output b_req_ready, b_rsp_valid, b_rsp_data,
    output busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// The lab's combinational 4-bit ALU; add and sub wrap mod 16, slt is unsigned.
module ALU
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] f
);

  always_comb begin
    f = 4'd0;
    case (op)
      OP_AND:  f = x & y;
      OP_OR:   f = x | y;
      OP_ADD:  f = x + y;
      OP_ZERO: f = 4'd0;
      OP_ANDN: f = x & ~y;
      OP_ORN:  f = x | ~y;
      OP_SUB:  f = x - y;
      OP_SLT:  f = {3'b000, (x < y)};
      default: f = 4'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between requesters A and B:
// accept in IDLE, compute from registered operands in EXEC, hold result in RESP.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  state_t     state_q, state_d;
  logic       prio_q;
  logic       own_q;
  logic [2:0] op_q;
  logic [3:0] x_q, y_q, res_q;
  logic [3:0] alu_f;
  logic       win;
  logic       accept;
  logic       rsp_hs;

  // Winner is only meaningful when at least one requester is valid.
  always_comb begin
    win = REQ_A;
    if (bus.a_req_valid && bus.b_req_valid) win = prio_q;
    else if (bus.b_req_valid)               win = REQ_B;
  end

  assign accept = (state_q == ST_IDLE) && (bus.a_req_valid || bus.b_req_valid);
  assign rsp_hs = (state_q == ST_RESP) &&
                  ((own_q == REQ_A) ? bus.a_rsp_ready : bus.b_rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.a_req_ready = 1'b0;
    bus.b_req_ready = 1'b0;
    bus.a_rsp_valid = 1'b0;
    bus.b_rsp_valid = 1'b0;
    bus.a_rsp_data  = res_q;
    bus.b_rsp_data  = res_q;
    bus.busy        = (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      bus.a_req_ready = bus.a_req_valid && (win == REQ_A);
      bus.b_req_ready = bus.b_req_valid && (win == REQ_B);
    end
    if (state_q == ST_RESP) begin
      bus.a_rsp_valid = (own_q == REQ_A);
      bus.b_rsp_valid = (own_q == REQ_B);
    end
  end

  // Operands are sampled only on the accept edge so later input changes are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 3'd0;
      x_q    <= 4'd0;
      y_q    <= 4'd0;
      own_q  <= REQ_A;
      res_q  <= 4'd0;
      prio_q <= REQ_A;
    end else begin
      if (accept) begin
        own_q <= win;
        op_q  <= (win == REQ_B) ? bus.b_op : bus.a_op;
        x_q   <= (win == REQ_B) ? bus.b_x  : bus.a_x;
        y_q   <= (win == REQ_B) ? bus.b_y  : bus.a_y;
      end
      if (state_q == ST_EXEC) res_q <= alu_f;
      if (rsp_hs) prio_q <= ~own_q;
    end
  end

  ALU u_alu (
    .op (op_q),
    .x  (x_q),
    .y  (y_q),
    .f  (alu_f)
  );

  assign dbg_state = state_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single 4-bit ALU between requesters A and B. Each requester submits an opcode and two operands over a valid/ready handshake. The block grants one requester at a time with round-robin fairness, registers the operands into the ALU, and returns the registered result over a per-requester valid/ready response channel. It sits between the lab's operand sources (switch/FSM front ends) and the shared ALU instance.

## Interface
- No parameters. Data width is fixed at 4 bits and opcode width at 3 bits, matching the ALU.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `a_req_valid` in 1 / `a_req_ready` out 1: requester A command handshake.
- `a_op` in 3, `a_x` in 4, `a_y` in 4: A's opcode, first operand, second operand.
- `a_rsp_valid` out 1 / `a_rsp_ready` in 1 / `a_rsp_data` out 4: A's result handshake.
- `b_req_valid`, `b_req_ready`, `b_op`, `b_x`, `b_y`, `b_rsp_valid`, `b_rsp_ready`, `b_rsp_data`: same as A, for requester B.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Only the selected winner's `*_req_ready` is driven high; the loser's is low. Ready is low in all other states.
  - Winner: if only one requester is valid, it wins. If both are valid, the requester named by `prio` wins.
  - On the accept edge (valid && ready): latch op/x/y into `op_q/x_q/y_q`, latch the owner into `own_q`, and go to EXEC.
- EXEC: ALU inputs come only from `op_q/x_q/y_q`. On the next edge, capture the ALU output into `res_q` and go to RESP.
- RESP:
  - `own_q`'s `*_rsp_valid` = 1; the other requester's is 0. Both `*_rsp_data` = `res_q`.
  - Hold until the owner's `*_rsp_ready` = 1. On that edge go to IDLE and set `prio` to the requester not served.
  - The other requester's `rsp_ready` is ignored.
- ALU results:
  - Opcodes 000 and, 001 or, 010 add, 011 zero, 100 x&~y, 101 x|~y, 110 sub, 111 set-less-than.
  - Add and sub wrap mod 16 with no carry out. Set-less-than is unsigned and yields 0001 or 0000.
- Request inputs are sampled only on the accept edge. Changes after acceptance have no effect.

## Timing
- Reset (async assert): state = IDLE, `prio` = A, `op_q/x_q/y_q/res_q` = 0, `own_q` = A.
  - All outputs 0: both `*_req_ready` = 0 (no requester valid), both `*_rsp_valid` = 0, both `*_rsp_data` = 0, `busy` = 0.
- Cycle numbering: accept edge E0. EXEC occupies the cycle after E0. Result capture at E1. `rsp_valid` is high from the cycle after E1.
- Best case: response handshake at E2, IDLE in the cycle after E2, next accept at E3. Minimum 3 cycles per operation.
- Backpressure: `rsp_valid` and `rsp_data` stay stable until the handshake.
- Simultaneous requests: served alternately A, B, A, B when both stay valid.
- A request arriving in EXEC or RESP waits; it is never dropped or overwritten.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded. No response is issued after reset release, and `prio` returns to A.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_AND` … `OP_SLT` (3'b000 … 3'b111);
  - state encodings `ST_IDLE` = 2'd0, `ST_EXEC` = 2'd1, `ST_RESP` = 2'd2;
  - requester IDs `REQ_A` = 1'b0, `REQ_B` = 1'b1.
- One sub-module: the existing 4-bit `ALU`, instantiated once as `u_alu` and fed from the operand registers.

## Test plan
- Reset: assert `rst_n` = 0 mid-run → all outputs 0, `busy` = 0, immediately (async).
- Single request: A sends op 010, x = 5, y = 3 → `a_rsp_valid` high 2 cycles after accept, `a_rsp_data` = 1000; B outputs stay 0.
- Arbitration: A and B both valid continuously; A sends 000 (F, 6), B sends 001 (9, 2) → A served first (0110), then B (1011), then A again.
- Backpressure: hold `b_rsp_ready` = 0 for 5 cycles on B op 110 (3, 5) → `b_rsp_valid` and data 1110 stable throughout; no new accept until handshake.
- Wrap and compare: 010 (F, 1) → 0000; 111 (2, 7) → 0001; 111 (7, 2) → 0000; 011 (any) → 0000.
- Reset in EXEC: accept A op 010 (1, 1), pull `rst_n` low in EXEC, release → no `a_rsp_valid`; the next simultaneous A/B request is granted to A.
